bcd_countdown_ctrl: RTL and testbench

Controller for a two-stage mm:ss BCD countdown timer built from the team's mod-60 BCD counter datapath, run in the decrement direction.
- Sequences load, run, pause and expiry with an FSM.
- Derives the 1 Hz decrement tick from a clk prescaler.
- Flags illegal commands.
- Sits between the front-panel command decoder and the display driver.

---
 rtl/bcd_countdown_ctrl_if.sv | 26 ++
 rtl/bcd_countdown_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_countdown_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_countdown_ctrl_if.sv
// rtl/bcd_countdown_ctrl_if.sv - command and display bus of the mm:ss countdown controller
// master drives commands and load data; slave reports time, state and status pulses.
interface bcd_countdown_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] state;
  logic       tick;
  logic       done;
  logic       err;

  modport master (
    output start, stop, clear, load, load_min, load_sec,
    input  min_bcd, sec_bcd, state, tick, done, err
  );

  modport slave (
    input  start, stop, clear, load, load_min, load_sec,
    output min_bcd, sec_bcd, state, tick, done, err
  );
endinterface

// File: rtl/bcd_countdown_ctrl.sv
// rtl/bcd_countdown_ctrl.sv - mm:ss BCD countdown controller with 1 Hz prescaler
// Commands are level-sampled each edge with priority clear > load > stop > start.
module bcd_countdown_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_countdown_ctrl_if.slave      bus
);

  localparam logic [1:0]  S_IDLE     = 2'b00;
  localparam logic [1:0]  S_RUN      = 2'b01;
  localparam logic [1:0]  S_PAUSE    = 2'b10;
  localparam logic [1:0]  S_DONE     = 2'b11;
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [1:0]  state_q, state_n;
  logic [7:0]  min_q, min_n;
  logic [7:0]  sec_q, sec_n;
  logic [15:0] presc_q, presc_n;
  logic        tick_q, tick_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic        act_zero, act_cap, act_count, act_presc_clr;
  logic [15:0] dec_time;
  logic        wrap, time_zero, dec_zero, load_ok;

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    // Borrow chain across the four digits; caller guarantees t is nonzero.
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
  endfunction

  assign dec_time  = bcd_dec({min_q, sec_q});
  assign wrap      = (presc_q == PRESC_LAST);
  assign time_zero = ({min_q, sec_q} == 16'h0000);
  assign dec_zero  = (dec_time == 16'h0000);
  assign load_ok   = bcd_ok(bus.load_min) && bcd_ok(bus.load_sec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      presc_q <= 16'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      presc_q <= presc_n;
      tick_q  <= tick_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    err_n         = 1'b0;
    act_zero      = 1'b0;
    act_cap       = 1'b0;
    act_count     = 1'b0;
    act_presc_clr = 1'b0;
    if (bus.clear) begin
      state_n  = S_IDLE;
      act_zero = 1'b1;
    end else if (bus.load) begin
      if ((state_q == S_IDLE || state_q == S_DONE) && load_ok) begin
        act_cap = 1'b1;
        state_n = S_IDLE;
      end else begin
        err_n = 1'b1;
      end
    end else if (bus.stop) begin
      if (state_q == S_RUN) state_n = S_PAUSE;
    end else if (bus.start && state_q != S_RUN) begin
      case (state_q)
        S_IDLE: begin
          if (time_zero) begin
            err_n = 1'b1;
          end else begin
            state_n       = S_RUN;
            act_presc_clr = 1'b1;
          end
        end
        S_PAUSE: state_n = S_RUN;
        default: err_n = 1'b1;
      endcase
    end else if (state_q == S_RUN) begin
      act_count = 1'b1;
      if (wrap && dec_zero) state_n = S_DONE;
    end
  end

  always_comb begin
    min_n   = min_q;
    sec_n   = sec_q;
    presc_n = presc_q;
    tick_n  = 1'b0;
    if (act_zero) begin
      min_n   = 8'h00;
      sec_n   = 8'h00;
      presc_n = 16'd0;
    end
    if (act_cap) begin
      min_n = bus.load_min;
      sec_n = bus.load_sec;
    end
    if (act_presc_clr) presc_n = 16'd0;
    if (act_count) begin
      if (wrap) begin
        presc_n        = 16'd0;
        {min_n, sec_n} = dec_time;
        tick_n         = 1'b1;
      end else begin
        presc_n = presc_q + 16'd1;
      end
    end
    done_n = (state_n == S_DONE);
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.state   = state_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// tb/tb_bcd_countdown_ctrl.sv - directed and random checks of bcd_countdown_ctrl
// Reference keeps time as plain seconds and a phase count within the current second.
module tb_bcd_countdown_ctrl;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bcd_countdown_ctrl_if bus();

  bcd_countdown_ctrl #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode;
  int m_secs;
  int m_phase;
  bit m_tick;
  bit m_err;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit byte_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_phase = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic check_model();
    chk("min_bcd", bus.min_bcd, to_bcd(m_secs / 60));
    chk("sec_bcd", bus.sec_bcd, to_bcd(m_secs % 60));
    chk("state", {6'b0, bus.state}, 8'(m_mode));
    chk("tick", {7'b0, bus.tick}, {7'b0, m_tick});
    chk("done", {7'b0, bus.done}, {7'b0, m_mode == 3});
    chk("err", {7'b0, bus.err}, {7'b0, m_err});
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_err  = 0;
    if (bus.clear) begin
      m_mode = 0; m_secs = 0; m_phase = 0;
    end else if (bus.load) begin
      if ((m_mode == 0 || m_mode == 3) && byte_ok(bus.load_min) && byte_ok(bus.load_sec)) begin
        m_secs = from_bcd(bus.load_min) * 60 + from_bcd(bus.load_sec);
        m_mode = 0;
      end else begin
        m_err = 1;
      end
    end else if (bus.stop) begin
      if (m_mode == 1) m_mode = 2;
    end else if (bus.start && m_mode != 1) begin
      if (m_mode == 0) begin
        if (m_secs == 0) m_err = 1;
        else begin m_mode = 1; m_phase = 0; end
      end else if (m_mode == 2) m_mode = 1;
      else m_err = 1;
    end else if (m_mode == 1) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        m_secs  = m_secs - 1;
        m_tick  = 1;
        if (m_secs == 0) m_mode = 3;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic step(input bit s, input bit p, input bit c, input bit l,
                      input logic [7:0] lm, input logic [7:0] ls);
    bus.start = s; bus.stop = p; bus.clear = c; bus.load = l;
    bus.load_min = lm; bus.load_sec = ls;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
    step(0, 0, 0, 1, lm, ls);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    bus.load_min = 8'h00; bus.load_sec = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;

    // 00:03 runs to expiry with ticks every TD cycles
    do_load(8'h00, 8'h03);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(3);
    chk("no_tick_e3", {7'b0, bus.tick}, 8'h00);
    idle(1);
    chk("tick_e4", {7'b0, bus.tick}, 8'h01);
    chk("sec_e4", bus.sec_bcd, 8'h02);
    idle(4);
    chk("sec_e8", bus.sec_bcd, 8'h01);
    idle(4);
    chk("sec_e12", bus.sec_bcd, 8'h00);
    chk("state_e12", {6'b0, bus.state}, 8'h03);
    chk("done_e12", {7'b0, bus.done}, 8'h01);
    idle(6);

    // Borrow cases
    step(0, 0, 1, 0, 8'h00, 8'h00);
    do_load(8'h01, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(4);
    chk("borrow_min", bus.min_bcd, 8'h00);
    chk("borrow_sec", bus.sec_bcd, 8'h59);
    step(0, 0, 1, 0, 8'h00, 8'h00);
    do_load(8'h10, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(4);
    chk("borrow_tens", {bus.min_bcd, bus.sec_bcd} == 16'h0959 ? 8'h01 : 8'h00, 8'h01);
    step(0, 0, 1, 0, 8'h00, 8'h00);
    do_load(8'h00, 8'h10);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(4);
    chk("sec_tens_borrow", bus.sec_bcd, 8'h09);

    // Pause holds the prescaler phase
    step(0, 0, 1, 0, 8'h00, 8'h00);
    do_load(8'h00, 8'h05);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00, 8'h00);
    chk("pause_state", {6'b0, bus.state}, 8'h02);
    chk("pause_sec", bus.sec_bcd, 8'h05);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(1);
    chk("resume_no_tick", {7'b0, bus.tick}, 8'h00);
    idle(1);
    chk("resume_tick", {7'b0, bus.tick}, 8'h01);
    chk("resume_sec", bus.sec_bcd, 8'h04);

    // Illegal commands
    step(0, 0, 1, 0, 8'h00, 8'h00);
    do_load(8'h00, 8'h6A);
    chk("bad_load_err", {7'b0, bus.err}, 8'h01);
    do_load(8'h00, 8'h05);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(1);
    do_load(8'h00, 8'h20);
    chk("run_load_err", {7'b0, bus.err}, 8'h01);
    idle(5);
    step(0, 0, 1, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    chk("zero_start_err", {7'b0, bus.err}, 8'h01);

    // start+stop in RUN, clear+load, clear on a pending tick
    do_load(8'h00, 8'h05);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(1, 1, 0, 0, 8'h00, 8'h00);
    chk("start_stop_pause", {6'b0, bus.state}, 8'h02);
    step(0, 0, 1, 1, 8'h12, 8'h34);
    chk("clear_load_sec", bus.sec_bcd, 8'h00);
    do_load(8'h00, 8'h05);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(3);
    step(0, 0, 1, 0, 8'h00, 8'h00);
    chk("clear_tick", {7'b0, bus.tick}, 8'h00);

    // Asynchronous reset mid-count
    do_load(8'h00, 8'h41);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(2);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0, 8'h00, 8'h00);
    chk("post_reset_err", {7'b0, bus.err}, 8'h01);
    do_load(8'h00, 8'h02);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle(9);
    chk("post_reset_done", {7'b0, bus.done}, 8'h01);

    // Random command mix
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] lm, ls;
      r  = int'($urandom_range(0, 99));
      lm = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 2))) : 8'($urandom);
      ls = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 59))) : 8'($urandom);
      step(r >= 18 && r < 32 || (r >= 10 && r < 12),
           r >= 10 && r < 18,
           r < 2,
           r >= 2 && r < 10,
           lm, ls);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
